// File: rtl/jtcontra_gfx_romslot_if.sv
// Graphics ROM slot bus: 007121 client request/response plus the SDRAM controller handshake.
// The master modport is the environment (client + SDRAM), the slave modport is the ROM slot.
interface jtcontra_gfx_romslot_if #(
    parameter int AW  = 18,
    parameter int SDW = 22
);
    logic            downloading;
    logic            rom_cs;
    logic [AW-1:0]   rom_addr;
    logic [15:0]     rom_data;
    logic            rom_ok;
    logic            sdram_req;
    logic [SDW-1:0]  sdram_addr;
    logic            sdram_ack;
    logic            sdram_dst;
    logic [15:0]     sdram_data;

    modport master (
        output downloading, rom_cs, rom_addr, sdram_ack, sdram_dst, sdram_data,
        input  rom_data, rom_ok, sdram_req, sdram_addr
    );

    modport slave (
        input  downloading, rom_cs, rom_addr, sdram_ack, sdram_dst, sdram_data,
        output rom_data, rom_ok, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtcontra_gfx_romslot.sv
// Graphics ROM responder for one 007121: tag cache in front of an SDRAM slot.
// Defining JTCONTRA_ROMSLOT_PREFETCH_EN adds a second entry filled by next-word prefetch.
module jtcontra_gfx_romslot #(
    parameter int             AW     = 18,
    parameter int             SDW    = 22,
    parameter logic [SDW-1:0] OFFSET = '0
)(
    input  logic                  rst,
    input  logic                  clk,
    jtcontra_gfx_romslot_if.slave bus
);

    // state    | meaning
    // IDLE     | serving hits, launching demand or prefetch requests
    // WAIT_ACK | sdram_req/sdram_addr held until the controller accepts
    // WAIT_DST | waiting for the data strobe to fill the cache
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_ACK, ST_WAIT_DST} state_t;

    state_t          r_state, w_next;
    logic            r_valid0;
    logic [AW-1:0]   r_tag0;
    logic [15:0]     r_data0;
    logic [AW-1:0]   r_req_addr;
    logic            r_ok;
    logic [AW-1:0]   r_ok_addr;
    logic [15:0]     r_data;
    logic            r_sdram_req;
    logic [SDW-1:0]  r_sdram_addr;

    logic            w_hit0, w_hit, w_miss;
    logic            w_issue_dem, w_issue_pf, w_issue, w_fill, w_fill_pf;
    logic [15:0]     w_hit_data;
    logic [AW-1:0]   w_issue_addr;

    assign w_hit0 = bus.rom_cs & r_valid0 & (r_tag0 == bus.rom_addr);

`ifdef JTCONTRA_ROMSLOT_PREFETCH_EN
    logic            r_valid1;
    logic [AW-1:0]   r_tag1;
    logic [15:0]     r_data1;
    logic            r_pf_pend;
    logic [AW-1:0]   r_pf_addr;
    logic            r_is_pf;
    logic            w_hit1;

    assign w_hit1       = bus.rom_cs & r_valid1 & (r_tag1 == bus.rom_addr);
    assign w_hit        = w_hit0 | w_hit1;
    assign w_hit_data   = w_hit0 ? r_data0 : r_data1;
    assign w_fill_pf    = r_is_pf;
    assign w_issue_addr = w_issue_pf ? r_pf_addr : bus.rom_addr;
`else
    assign w_hit        = w_hit0;
    assign w_hit_data   = r_data0;
    assign w_fill_pf    = 1'b0;
    assign w_issue_addr = bus.rom_addr;
`endif

    assign w_miss  = bus.rom_cs & ~w_hit;
    assign w_issue = w_issue_dem | w_issue_pf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_issue_dem = 1'b0;
        w_issue_pf  = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.downloading && w_miss) begin
                    w_issue_dem = 1'b1;
                    w_next      = ST_WAIT_ACK;
                end
`ifdef JTCONTRA_ROMSLOT_PREFETCH_EN
                else if (!bus.downloading && r_pf_pend) begin
                    w_issue_pf = 1'b1;
                    w_next     = ST_WAIT_ACK;
                end
`endif
            end
            ST_WAIT_ACK: begin
                // ack and dst together behave as ack immediately followed by dst
                if (bus.sdram_ack) begin
                    if (bus.sdram_dst) begin
                        w_fill = 1'b1;
                        w_next = ST_IDLE;
                    end else begin
                        w_next = ST_WAIT_DST;
                    end
                end
            end
            ST_WAIT_DST: begin
                if (bus.sdram_dst) begin
                    w_fill = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sdram_req  <= 1'b0;
            r_sdram_addr <= '0;
            r_req_addr   <= '0;
        end else if (w_issue) begin
            r_sdram_req  <= 1'b1;
            r_sdram_addr <= OFFSET + SDW'(w_issue_addr);
            r_req_addr   <= w_issue_addr;
        end else if (r_state == ST_WAIT_ACK && bus.sdram_ack) begin
            r_sdram_req  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid0 <= 1'b0;
            r_tag0   <= '0;
            r_data0  <= '0;
        end else begin
            if (w_fill && !w_fill_pf) begin
                r_tag0  <= r_req_addr;
                r_data0 <= bus.sdram_data;
            end
            if (bus.downloading)
                r_valid0 <= 1'b0;
            else if (w_fill && !w_fill_pf)
                r_valid0 <= 1'b1;
        end
    end

`ifdef JTCONTRA_ROMSLOT_PREFETCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid1  <= 1'b0;
            r_tag1    <= '0;
            r_data1   <= '0;
            r_pf_pend <= 1'b0;
            r_pf_addr <= '0;
            r_is_pf   <= 1'b0;
        end else begin
            if (w_issue)
                r_is_pf <= w_issue_pf;
            if (w_fill && r_is_pf) begin
                r_tag1  <= r_req_addr;
                r_data1 <= bus.sdram_data;
            end
            if (bus.downloading)
                r_valid1 <= 1'b0;
            else if (w_fill && r_is_pf)
                r_valid1 <= 1'b1;
            // only a demand fill arms the next-word prefetch
            if (bus.downloading || w_issue)
                r_pf_pend <= 1'b0;
            else if (w_fill && !r_is_pf) begin
                r_pf_pend <= 1'b1;
                r_pf_addr <= r_req_addr + AW'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ok      <= 1'b0;
            r_ok_addr <= '0;
            r_data    <= '0;
        end else if (bus.downloading) begin
            r_ok      <= 1'b0;
        end else if (w_hit) begin
            r_ok      <= 1'b1;
            r_ok_addr <= bus.rom_addr;
            r_data    <= w_hit_data;
        end else begin
            r_ok      <= 1'b0;
        end
    end

    // address compare keeps rom_ok from vouching for a stale request
    assign bus.rom_ok     = r_ok & bus.rom_cs & (bus.rom_addr == r_ok_addr);
    assign bus.rom_data   = r_data;
    assign bus.sdram_req  = r_sdram_req;
    assign bus.sdram_addr = r_sdram_addr;

endmodule

// File: tb/tb_jtcontra_gfx_romslot.sv
// Self-checking bench for jtcontra_gfx_romslot: scoreboard queues of expected SDRAM addresses and read data.
module tb_jtcontra_gfx_romslot;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef JTCONTRA_ROMSLOT_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    jtcontra_gfx_romslot_if #(.AW(18), .SDW(22)) bus0();
    jtcontra_gfx_romslot_if #(.AW(18), .SDW(22)) bus1();

    jtcontra_gfx_romslot #(.AW(18), .SDW(22), .OFFSET(22'h0)) u_dut0 (
        .rst (rst),
        .clk (clk),
        .bus (bus0)
    );

    jtcontra_gfx_romslot #(.AW(18), .SDW(22), .OFFSET(22'h100000)) u_dut1 (
        .rst (rst),
        .clk (clk),
        .bus (bus1)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [21:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_ok(input string tag);
        logic [15:0] e;
        e = exp_data_q.pop_front();
        chk({tag, "_ok"}, {31'd0, bus0.rom_ok}, 32'd1);
        chk({tag, "_data"}, {16'd0, bus0.rom_data}, {16'd0, e});
    endtask

    // SDRAM model: waits for a request, then acks/strobes after the given negedge counts
    task automatic sdram_serve(input int ack_dly, input int dst_dly, input logic [15:0] d);
        logic [21:0] ea;
        int n;
        n = 0;
        while (bus0.sdram_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ea = exp_addr_q.pop_front();
        chk("req_seen", {31'd0, bus0.sdram_req}, 32'd1);
        chk("sdram_addr", {10'd0, bus0.sdram_addr}, {10'd0, ea});
        repeat (ack_dly - 1) @(negedge clk);
        chk("req_held", {9'd0, bus0.sdram_req, bus0.sdram_addr}, {9'd0, 1'b1, ea});
        bus0.sdram_ack = 1'b1;
        if (dst_dly == ack_dly) begin
            bus0.sdram_dst  = 1'b1;
            bus0.sdram_data = d;
        end
        @(negedge clk);
        bus0.sdram_ack = 1'b0;
        bus0.sdram_dst = 1'b0;
        chk("req_drop", {31'd0, bus0.sdram_req}, 32'd0);
        if (dst_dly > ack_dly) begin
            repeat (dst_dly - ack_dly - 1) @(negedge clk);
            bus0.sdram_dst  = 1'b1;
            bus0.sdram_data = d;
            @(negedge clk);
            bus0.sdram_dst  = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.downloading = 1'b0; bus0.rom_cs = 1'b0; bus0.rom_addr = '0;
        bus0.sdram_ack = 1'b0; bus0.sdram_dst = 1'b0; bus0.sdram_data = '0;
        bus1.downloading = 1'b0; bus1.rom_cs = 1'b0; bus1.rom_addr = '0;
        bus1.sdram_ack = 1'b0; bus1.sdram_dst = 1'b0; bus1.sdram_data = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ok", {31'd0, bus0.rom_ok}, 32'd0);
        chk("rst_data", {16'd0, bus0.rom_data}, 32'd0);
        chk("rst_req", {31'd0, bus0.sdram_req}, 32'd0);
        chk("rst_addr", {10'd0, bus0.sdram_addr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // demand miss, ack after 3, dst after 5
        exp_addr_q.push_back(22'h000123);
        exp_data_q.push_back(16'hBEEF);
        bus0.rom_cs = 1'b1; bus0.rom_addr = 18'h00123;
        @(negedge clk);
        sdram_serve(3, 5, 16'hBEEF);
        chk("miss_ok_early", {31'd0, bus0.rom_ok}, 32'd0);
        @(negedge clk);
        expect_ok("miss_fill");
        chk("req_after_demand", {31'd0, bus0.sdram_req}, {31'd0, PF});
`ifdef JTCONTRA_ROMSLOT_PREFETCH_EN
        exp_addr_q.push_back(22'h000124);
        sdram_serve(1, 2, 16'h0124);
        @(negedge clk);
`endif

        // hit after dropping rom_cs for one cycle
        bus0.rom_cs = 1'b0;
        @(negedge clk);
        chk("ok_cs_low", {31'd0, bus0.rom_ok}, 32'd0);
        bus0.rom_cs = 1'b1;
        #1;
        chk("hit_lat0", {31'd0, bus0.rom_ok}, 32'd0);
        exp_data_q.push_back(16'hBEEF);
        @(negedge clk);
        expect_ok("hit");
        chk("hit_no_req", {31'd0, bus0.sdram_req}, 32'd0);

        // non-zero offset instance
        bus1.rom_cs = 1'b1; bus1.rom_addr = 18'h00010;
        @(negedge clk);
        chk("off_req", {31'd0, bus1.sdram_req}, 32'd1);
        chk("off_addr", {10'd0, bus1.sdram_addr}, 32'h00100010);
        bus1.rom_cs = 1'b0;

        // address change while waiting for ack
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus0.rom_addr = 18'h00123;
        @(negedge clk);
        chk("chg_req", {31'd0, bus0.sdram_req}, 32'd1);
        chk("chg_addr", {10'd0, bus0.sdram_addr}, 32'h00000123);
        bus0.rom_addr = 18'h00200;
        #1;
        chk("chg_ok0", {31'd0, bus0.rom_ok}, 32'd0);
        @(negedge clk);
        chk("chg_addr_held", {10'd0, bus0.sdram_addr}, 32'h00000123);
        bus0.sdram_ack = 1'b1;
        @(negedge clk);
        bus0.sdram_ack = 1'b0;
        @(negedge clk);
        bus0.sdram_dst = 1'b1; bus0.sdram_data = 16'hAAAA;
        @(negedge clk);
        bus0.sdram_dst = 1'b0;
        chk("chg_ok_old", {31'd0, bus0.rom_ok}, 32'd0);
        exp_addr_q.push_back(22'h000200);
        exp_data_q.push_back(16'h5555);
        sdram_serve(2, 4, 16'h5555);
        chk("chg_ok_early", {31'd0, bus0.rom_ok}, 32'd0);
        @(negedge clk);
        expect_ok("chg_fill");

        // simultaneous ack and dst
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus0.rom_addr = 18'h00777;
        exp_addr_q.push_back(22'h000777);
        exp_data_q.push_back(16'h1234);
        sdram_serve(2, 2, 16'h1234);
        chk("sim_ok_early", {31'd0, bus0.rom_ok}, 32'd0);
        @(negedge clk);
        expect_ok("sim_fill");

        // download during WAIT_DST
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus0.rom_addr = 18'h00055;
        @(negedge clk);
        chk("dl_req", {31'd0, bus0.sdram_req}, 32'd1);
        chk("dl_addr", {10'd0, bus0.sdram_addr}, 32'h00000055);
        bus0.sdram_ack = 1'b1;
        @(negedge clk);
        bus0.sdram_ack = 1'b0;
        bus0.downloading = 1'b1;
        @(negedge clk);
        bus0.sdram_dst = 1'b1; bus0.sdram_data = 16'h9999;
        @(negedge clk);
        bus0.sdram_dst = 1'b0;
        chk("dl_ok0", {31'd0, bus0.rom_ok}, 32'd0);
        repeat (3) @(negedge clk);
        chk("dl_no_req", {31'd0, bus0.sdram_req}, 32'd0);
        chk("dl_ok1", {31'd0, bus0.rom_ok}, 32'd0);
        bus0.downloading = 1'b0;
        exp_addr_q.push_back(22'h000055);
        @(negedge clk);
        chk("dl_refetch_req", {31'd0, bus0.sdram_req}, 32'd1);
        chk("dl_refetch_addr", {10'd0, bus0.sdram_addr}, {10'd0, exp_addr_q.pop_front()});

        // reset while in WAIT_ACK, then stray late pulses
        #1 rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, bus0.sdram_req}, 32'd0);
        chk("arst_ok", {31'd0, bus0.rom_ok}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus0.rom_cs = 1'b0;
        bus0.sdram_ack = 1'b1; bus0.sdram_dst = 1'b1; bus0.sdram_data = 16'h7777;
        @(negedge clk);
        bus0.sdram_ack = 1'b0; bus0.sdram_dst = 1'b0;
        @(negedge clk);
        chk("late_req", {31'd0, bus0.sdram_req}, 32'd0);
        chk("late_data", {16'd0, bus0.rom_data}, 32'd0);

`ifdef JTCONTRA_ROMSLOT_PREFETCH_EN
        // prefetch wraps from the top of the window
        bus0.rom_cs = 1'b1; bus0.rom_addr = 18'h3FFFF;
        exp_addr_q.push_back(22'h03FFFF);
        exp_data_q.push_back(16'hCAFE);
        sdram_serve(1, 2, 16'hCAFE);
        chk("pf_ok_early", {31'd0, bus0.rom_ok}, 32'd0);
        @(negedge clk);
        expect_ok("pf_demand");
        exp_addr_q.push_back(22'h000000);
        sdram_serve(1, 2, 16'h0BAD);
        bus0.rom_addr = 18'h00000;
        #1;
        chk("pf_lat0", {31'd0, bus0.rom_ok}, 32'd0);
        exp_data_q.push_back(16'h0BAD);
        @(negedge clk);
        expect_ok("pf_hit");
        chk("pf_no_chain", {31'd0, bus0.sdram_req}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jtcontra_gfx_romslot.md
Name: jtcontra_gfx_romslot

Overview:
- Responder end of the graphics ROM request interface (rom_cs/rom_addr → rom_data/rom_ok) driven by the 007121 graphics block's local SDRAM mux.
- Services word reads from an 18-bit graphics ROM window by issuing transactions to the SDRAM controller, with a small address-tagged cache.
- Sits between one 007121 instance and its SDRAM controller slot, in the clk domain.

Parameters:
- AW, 18, client word-address width.
- SDW, 22, SDRAM word-address width.
- OFFSET, 22'h0, SDRAM word offset added to every client address.

Ports:
- rst  in  1  reset, asynchronous, active-high
- clk  in  1  clock
- downloading  in  1  ROM download in progress; invalidates the cache and blocks new SDRAM requests
- rom_cs  in  1  client request strobe
- rom_addr  in  AW  client word address
- rom_data  out  16  returned word
- rom_ok  out  1  rom_data valid for the current rom_addr
- sdram_req  out  1  SDRAM request, held until acknowledged
- sdram_addr  out  SDW  SDRAM word address
- sdram_ack  in  1  SDRAM accepted the request (1-cycle pulse)
- sdram_dst  in  1  sdram_data valid (1-cycle pulse)
- sdram_data  in  16  SDRAM read data

Behaviour:
- Reset values: rom_ok=0, rom_data=0, sdram_req=0, sdram_addr=0, FSM=IDLE, all cache valid bits=0.
- Cache entry 0 holds tag[AW], data[16] and a valid bit.
- Hit: rom_cs=1, the entry is valid and its tag equals rom_addr.
- Output gating: ok_r, ok_addr and data_r are registered. rom_ok = ok_r & rom_cs & (rom_addr==ok_addr), gated combinationally so rom_ok never reports a stale address.
- On a hit, ok_r=1, ok_addr=rom_addr and data_r=entry data on the next clk. Hit latency is 1 clk.
- rom_data = data_r.
- ok_r clears the cycle after rom_cs=0 or after any miss.
- FSM states: IDLE, WAIT_ACK, WAIT_DST.
- IDLE: on a miss with downloading=0, latch req_addr=rom_addr, set sdram_addr=OFFSET+{zero-extended req_addr} (mod 2^SDW), assert sdram_req and go to WAIT_ACK.
- WAIT_ACK: hold sdram_req and sdram_addr stable until sdram_ack. Then sdram_req=0 and go to WAIT_DST.
- WAIT_DST: on sdram_dst, write entry {tag=req_addr, data=sdram_data, valid=1} and go to IDLE. The hit path then asserts rom_ok one clk later if rom_cs/rom_addr still match.
- Miss latency: 1 (req) + ack wait + dst wait + 1 clk.
- sdram_ack and sdram_dst in the same cycle while in WAIT_ACK: treat as ack followed by dst. Capture the data and go straight to IDLE.
- Client changes rom_addr or drops rom_cs mid-transaction: the outstanding SDRAM transaction is never aborted. It completes, fills the cache, then the FSM re-evaluates in IDLE.
- Stray sdram_ack/sdram_dst in IDLE: ignored.
- downloading=1:
  - Clears all valid bits and ok_r every cycle.
  - An in-flight transaction completes but does not set valid.
  - No new request is issued until downloading=0.
- Reset mid-transaction: asynchronous clear of all state and sdram_req=0 immediately. Late ack/dst pulses after reset are ignored.

Optional Feature:
- Macro: JTCONTRA_ROMSLOT_PREFETCH_EN.
- With the macro defined:
  - A second entry (entry 1) is added.
  - A hit in either entry is served.
  - After a demand fill at address A completes, if no miss is pending in IDLE, the FSM issues a prefetch of A+1 (wraps mod 2^AW) into entry 1.
  - A prefetch never triggers a further prefetch.
  - A demand miss arriving during a prefetch waits for the prefetch to complete, then is serviced.
  - A prefetch fill at an address equal to the current rom_addr counts as a hit.
- Without the macro: single entry, no prefetch; sdram_req is asserted only for demand misses.

Test Plan:
- Miss fill: after reset, rom_cs=1, rom_addr=18'h00123; SDRAM acks after 3 clk and dst after 5 clk with 16'hBEEF → sdram_addr=22'h000123 with OFFSET=0; rom_ok=1 and rom_data=16'hBEEF exactly 1 clk after dst.
- Hit latency: repeat the read of 18'h00123 after dropping rom_cs for one cycle → rom_ok=1 one clk after rom_cs with no sdram_req; OFFSET=22'h100000 on a new miss at 18'h00010 → sdram_addr=22'h100010.
- Address change: rom_addr switches 18'h00123→18'h00200 in WAIT_ACK → rom_ok stays 0 for 18'h00200; first transaction completes, then a second sdram_req for 22'h000200 is issued; rom_ok=1 after its dst.
- Simultaneous ack+dst in one cycle with data 16'h1234 → FSM returns to IDLE; rom_ok=1 next clk.
- Download/reset: downloading=1 during WAIT_DST → no cache valid set, rom_ok=0, no new sdram_req; rst pulse in WAIT_ACK → sdram_req=0 immediately, rom_ok=0.
- PREFETCH_EN: miss at 18'h3FFFF → demand fill, then automatic sdram_req at 22'h000000 (wrap); a subsequent read of 18'h00000 hits with 1-clk latency.
